mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the processor's memory port (Address, Wr, Datain, Dataout), replacing the bare RAM on that port.
- Contents: byte-addressed big-endian RAM, exception-vector bytes at 254/255, a small MMIO window (output latch, cycle counter, write counter), and a byte loader port for preloading programs.
- After reset, an init sequencer scrubs the RAM before it serves the processor.

Parameters:
- MEM_BYTES, 256, RAM size in bytes; must be a power of two, at least 256.
- VEC_OPCODE, 8'h00, value restored into byte 254 (unknown-opcode handler address).
- VEC_OVERFLOW, 8'h00, value restored into byte 255 (overflow handler address).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Address  in  32  byte address from the processor.
- Wr  in  1  write strobe; 1 = word write this cycle.
- Datain  in  32  write data, big-endian word.
- Dataout  out  32  registered read data.
- Ready  out  1  high once init is complete.
- Load_en  in  1  loader byte-write strobe.
- Load_addr  in  8  loader byte address (low log2(MEM_BYTES) bits used).
- Load_byte  in  8  loader data.
- Out_reg  out  32  MMIO output latch.

Behaviour:
- Reset (synchronous, Reset high at edge):
  - Dataout=0, Out_reg=0, Ready=0, cycle counter=0, write counter=0, init index=0.
  - FSM goes to INIT.
  - Reset asserted mid-INIT or in RUN restarts INIT from index 0.
- FSM states: INIT, RUN.
  - INIT: each cycle write byte[idx]. Value is VEC_OPCODE at idx 254, VEC_OVERFLOW at idx 255, else 0. Then idx increments.
  - INIT lasts exactly MEM_BYTES cycles. At idx=MEM_BYTES-1, next state is RUN; Ready=1 from the following cycle.
  - INIT: Wr, Load_en and MMIO writes are ignored; Dataout held 0; counters frozen.
  - RUN: stays in RUN until Reset.
- Address decode (RUN):
  - Address[31]=0: RAM at index Address mod MEM_BYTES.
  - Address[31]=1: MMIO. Offset Address[3:2]: 0=Out_reg, 1=cycle counter, 2=write counter, 3=reads 0 / writes ignored.
- RAM read:
  - Dataout <= {b[a], b[a+1], b[a+2], b[a+3]}, indices mod MEM_BYTES, i.e. wraps (a=255 reads b255,b0,b1,b2).
  - One-cycle latency: Address at edge N appears on Dataout after edge N.
  - Dataout updates every RUN cycle, including write cycles.
- RAM write (Wr=1): b[a]<=Datain[31:24], b[a+1]<=[23:16], b[a+2]<=[15:8], b[a+3]<=[7:0], with the same wrap.
- Read-during-write, same address, same cycle: Dataout returns pre-write contents.
- Unaligned addresses are legal for both read and write; no alignment check.
- MMIO write to offset 0: Out_reg <= Datain. MMIO writes to offsets 1/2 are ignored (counters are read-only). MMIO reads are registered with one-cycle latency.
- Cycle counter: +1 every RUN cycle, 32-bit wrap.
- Write counter: +1 on every accepted Wr=1 cycle in RUN, RAM or MMIO, 32-bit wrap.
- Loader:
  - In RUN, Load_en=1 writes b[Load_addr]<=Load_byte.
  - If it hits a byte the processor is writing in the same cycle, the loader wins for that byte; the processor's other bytes still commit.
  - Loader writes do not increment the write counter.
- Vector bytes 254/255 are ordinary RAM in RUN and may be overwritten.
- X on Address while Wr=0 must not corrupt state.

Decomposition:
- Shared package mem_pkg:
  - state enum {INIT, RUN};
  - MMIO base bit index (31);
  - MMIO offsets OUT=0, CYC=1, WCNT=2;
  - vector addresses 254/255.
- One natural sub-module, mem_init_seq: INIT/RUN FSM, index counter, Ready, and generation of the init write value.
- Top level holds the byte array, decode, counters and the read register.

Test Plan:
- Reset held 1 cycle, VEC_OPCODE=8'hA5, VEC_OVERFLOW=8'h3C.
  - Ready=0 for exactly 256 cycles, then 1.
  - Read Address=254 -> Dataout=32'hA53C0000 next cycle.
- Word write and wrap:
  - RUN, Wr=1, Address=16, Datain=32'h11223344; next cycle read 16 -> 32'h11223344; read 17 -> 32'h22334400.
  - Write 32'hDEADBEEF at 255, then read 255 -> 32'hDEADBEEF; read 0 -> 32'hADBEEF00 (b0..b2 = AD,BE,EF from the wrap; b3 still 00).
- Read-during-write: 32'h0 stored at 8; write 32'hCAFEF00D to 8 while reading 8 -> Dataout=0 that cycle, 32'hCAFEF00D on the next read.
- MMIO:
  - Write 32'h55 to 32'h80000000 -> Out_reg=32'h55.
  - Three Wr cycles -> read 32'h80000008 returns 3 (plus prior writes).
  - Two back-to-back reads of 32'h80000004 differ by 1.
- Loader collision: same cycle, Load_en at addr 40 with 8'h77 and Wr word 32'h01020304 at 40 -> read 40 returns 32'h77020304; write counter +1 only.
- Reset mid-INIT: Reset at cycle 100 of INIT -> Ready stays 0 a further 256 cycles. Wr issued during INIT leaves the RAM at 0, and the write counter stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state enum, MMIO decode constants and vector addresses for mem_responder
package mem_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int MMIO_BIT = 31;
  localparam logic [1:0] OFF_OUT = 2'd0;
  localparam logic [1:0] OFF_CYC = 2'd1;
  localparam logic [1:0] OFF_WCNT = 2'd2;
  localparam int VEC_OPCODE_ADDR = 254;
  localparam int VEC_OVERFLOW_ADDR = 255;
endpackage

// File: rtl/mem_init_seq.sv
// mem_init_seq: INIT/RUN sequencer; ports clk, rst in; ready out high in RUN; init_we/init_idx/init_val drive one scrub byte per INIT cycle
module mem_init_seq
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter logic [7:0] VEC_OPCODE = 8'h00,
  parameter logic [7:0] VEC_OVERFLOW = 8'h00,
  parameter int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          init_we,
  output logic [AW-1:0] init_idx,
  output logic [7:0]    init_val
);
  state_t state, state_nx;
  logic [AW-1:0] idx_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_nx;
      init_idx <= idx_nx;
    end
  end
  always_comb begin
    state_nx = state;
    idx_nx = init_idx;
    if (state == INIT) begin
      idx_nx = init_idx + AW'(1);
      state_nx = init_idx == AW'(MEM_BYTES - 1) ? RUN : INIT;
    end
  end
  assign ready = state == RUN;
  assign init_we = state == INIT;
  assign init_val = init_idx == AW'(VEC_OPCODE_ADDR) ? VEC_OPCODE :
                    init_idx == AW'(VEC_OVERFLOW_ADDR) ? VEC_OVERFLOW : 8'h00;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: big-endian byte RAM + MMIO (Out_reg, cycle/write counters) + byte loader behind a scrub-on-reset sequencer; Clk/Reset in, Address/Wr/Datain in, Dataout/Ready/Out_reg out, Load_en/Load_addr/Load_byte in
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter logic [7:0] VEC_OPCODE = 8'h00,
  parameter logic [7:0] VEC_OVERFLOW = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ready,
  input  logic        Load_en,
  input  logic [7:0]  Load_addr,
  input  logic [7:0]  Load_byte,
  output logic [31:0] Out_reg
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [7:0] mem [MEM_BYTES];
  logic init_we;
  logic [AW-1:0] init_idx;
  logic [7:0] init_val;
  logic [31:0] cyc_cnt, wr_cnt, mmio_rd, ram_rd;
  logic [AW-1:0] a0, a1, a2, a3;
  logic act, is_mmio, ram_we, ld_we;
  mem_init_seq #(
    .MEM_BYTES(MEM_BYTES),
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVERFLOW(VEC_OVERFLOW)
  ) u_seq (
    .clk(Clk),
    .rst(Reset),
    .ready(Ready),
    .init_we(init_we),
    .init_idx(init_idx),
    .init_val(init_val)
  );
  assign act = Ready && !Reset;
  assign is_mmio = Address[MMIO_BIT];
  assign ram_we = act && Wr && !is_mmio;
  assign ld_we = act && Load_en;
  assign a0 = Address[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign ram_rd = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign mmio_rd = Address[3:2] == OFF_OUT ? Out_reg :
                   Address[3:2] == OFF_CYC ? cyc_cnt :
                   Address[3:2] == OFF_WCNT ? wr_cnt : '0;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Dataout <= '0;
      Out_reg <= '0;
      cyc_cnt <= '0;
      wr_cnt <= '0;
    end else if (Ready) begin
      Dataout <= is_mmio ? mmio_rd : ram_rd;
      cyc_cnt <= cyc_cnt + 32'd1;
      if (Wr) wr_cnt <= wr_cnt + 32'd1;
      if (Wr && is_mmio && Address[3:2] == OFF_OUT) Out_reg <= Datain;
    end
  end
  // loader write comes last so it overrides a colliding processor byte
  always_ff @(posedge Clk) begin
    if (init_we) mem[init_idx] <= init_val;
    if (ram_we) begin
      mem[a0] <= Datain[31:24];
      mem[a1] <= Datain[23:16];
      mem[a2] <= Datain[15:8];
      mem[a3] <= Datain[7:0];
    end
    if (ld_we) mem[AW'(Load_addr)] <= Load_byte;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder
module tb_mem_responder;
  logic Clk = 1'b0;
  logic Reset, Wr, Load_en, Ready;
  logic [31:0] Address, Datain, Dataout, Out_reg;
  logic [7:0] Load_addr, Load_byte;
  int n_cmp = 0;
  int n_bad = 0;
  int nrun = 0;
  int cnt;
  logic [31:0] exp_q[$];
  string tag_q[$];
  always #5 Clk = ~Clk;
  mem_responder #(
    .MEM_BYTES(256),
    .VEC_OPCODE(8'hA5),
    .VEC_OVERFLOW(8'h3C)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Address(Address),
    .Wr(Wr),
    .Datain(Datain),
    .Dataout(Dataout),
    .Ready(Ready),
    .Load_en(Load_en),
    .Load_addr(Load_addr),
    .Load_byte(Load_byte),
    .Out_reg(Out_reg)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp,
                     input logic le = 1'b0, input logic [7:0] la = 8'h00, input logic [7:0] lb = 8'h00);
    Wr = w;
    Address = a;
    Datain = d;
    Load_en = le;
    Load_addr = la;
    Load_byte = lb;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge Clk);
    @(negedge Clk);
    nrun++;
    Wr = 1'b0;
    Load_en = 1'b0;
    if (chk) check(tag_q.pop_front(), Dataout, exp_q.pop_front());
  endtask
  initial begin
    Reset = 1'b1;
    Wr = 1'b0;
    Address = '0;
    Datain = '0;
    Load_en = 1'b0;
    Load_addr = '0;
    Load_byte = '0;
    @(posedge Clk);
    @(negedge Clk);
    check("reset_dataout", Dataout, 32'h0);
    check("reset_out_reg", Out_reg, 32'h0);
    check("reset_ready", {31'd0, Ready}, 32'd0);
    Reset = 1'b0;
    Wr = 1'b1;
    Address = 32'd8;
    Datain = 32'hFFFFFFFF;
    Load_en = 1'b1;
    Load_addr = 8'd8;
    Load_byte = 8'hFF;
    repeat (100) @(negedge Clk);
    check("init_ready_mid", {31'd0, Ready}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0;
    while (!Ready && cnt < 1000) begin
      cnt++;
      @(negedge Clk);
    end
    check("init_len_after_rst", cnt, 32'd256);
    check("init_dataout_held", Dataout, 32'h0);
    check("init_out_reg", Out_reg, 32'h0);
    Wr = 1'b0;
    Load_en = 1'b0;
    cyc("vectors", 0, 32'd254, 0, 1, 32'hA53C0000);
    cyc("init_wr_ignored", 0, 32'd8, 0, 1, 32'h0);
    cyc("wcnt_zero", 0, 32'h80000008, 0, 1, 32'h0);
    cyc("wr16", 1, 32'd16, 32'h11223344, 0, 0);
    cyc("rd16", 0, 32'd16, 0, 1, 32'h11223344);
    cyc("rd17_unaligned", 0, 32'd17, 0, 1, 32'h22334400);
    cyc("wr255", 1, 32'd255, 32'hDEADBEEF, 0, 0);
    cyc("rd255_wrap", 0, 32'd255, 0, 1, 32'hDEADBEEF);
    cyc("rd0_wrap", 0, 32'd0, 0, 1, 32'hADBEEF00);
    cyc("rd252_vec_overwrite", 0, 32'd252, 0, 1, 32'h0000A5DE);
    cyc("rdw_old", 1, 32'd8, 32'hCAFEF00D, 1, 32'h0);
    cyc("rdw_new", 0, 32'd8, 0, 1, 32'hCAFEF00D);
    cyc("mmio_out_wr", 1, 32'h80000000, 32'h55, 0, 0);
    check("out_reg", Out_reg, 32'h55);
    cyc("mmio_cyc_wr", 1, 32'h80000004, 32'h123, 0, 0);
    cyc("mmio_wcnt_wr", 1, 32'h80000008, 32'h999, 0, 0);
    cyc("mmio_off3_wr", 1, 32'h8000000C, 32'h7, 0, 0);
    check("out_reg_kept", Out_reg, 32'h55);
    cyc("wcnt7", 0, 32'h80000008, 0, 1, 32'd7);
    cyc("mmio_out_rd", 0, 32'h80000000, 0, 1, 32'h55);
    cyc("cyc_a", 0, 32'h80000004, 0, 1, 32'(nrun));
    cyc("cyc_b", 0, 32'h80000004, 0, 1, 32'(nrun));
    cyc("collide", 1, 32'd40, 32'h01020304, 0, 0, 1'b1, 8'd40, 8'h77);
    cyc("rd40_loader_wins", 0, 32'd40, 0, 1, 32'h77020304);
    cyc("wcnt8", 0, 32'h80000008, 0, 1, 32'd8);
    cyc("loader_only", 0, 32'd0, 0, 0, 0, 1'b1, 8'd3, 8'h9A);
    cyc("rd0_loader", 0, 32'd0, 0, 1, 32'hADBEEF9A);
    cyc("wcnt8_loader", 0, 32'h80000008, 0, 1, 32'd8);
    cyc("off3_rd", 0, 32'h8000000C, 0, 1, 32'h0);
    check("q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
